// File: rtl/cplx_mult_pkg.sv
// Shared types for the complex-multiplier driver: FSM encoding, operand set, result width.
package cplx_mult_pkg;

  localparam int OP_W = 8;

  function automatic int res_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  localparam int RES_W = res_w(OP_W);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_ISSUE    = 2'b01;
  localparam logic [1:0] ST_WAIT_RES = 2'b10;

  typedef struct packed {
    logic signed [OP_W-1:0] a_re;
    logic signed [OP_W-1:0] a_im;
    logic signed [OP_W-1:0] b_re;
    logic signed [OP_W-1:0] b_im;
  } op_set_t;

endpackage

// File: rtl/cplx_mult_driver_if.sv
// Handshake bundle around the driver: upstream operands, multiplier control, downstream results.
interface cplx_mult_driver_if
  import cplx_mult_pkg::*;
#(
  parameter int DATA_W = OP_W
);
  localparam int RW = res_w(DATA_W);

  logic                     in_val;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a_re;
  logic signed [DATA_W-1:0] in_a_im;
  logic signed [DATA_W-1:0] in_b_re;
  logic signed [DATA_W-1:0] in_b_im;

  logic                     op_val;
  logic                     op_ready;
  logic signed [DATA_W-1:0] op_a_re;
  logic signed [DATA_W-1:0] op_a_im;
  logic signed [DATA_W-1:0] op_b_re;
  logic signed [DATA_W-1:0] op_b_im;

  logic                     res_val;
  logic                     res_ready;
  logic signed [RW-1:0]     res_re;
  logic signed [RW-1:0]     res_im;

  logic                     out_val;
  logic                     out_ready;
  logic signed [RW-1:0]     out_re;
  logic signed [RW-1:0]     out_im;

  // master: the driver itself; slave: everything around it
  modport master (
    input  in_val, in_a_re, in_a_im, in_b_re, in_b_im,
    output in_ready,
    output op_val, op_a_re, op_a_im, op_b_re, op_b_im,
    input  op_ready,
    input  res_val, res_re, res_im,
    output res_ready,
    output out_val, out_re, out_im,
    input  out_ready
  );

  modport slave (
    output in_val, in_a_re, in_a_im, in_b_re, in_b_im,
    input  in_ready,
    input  op_val, op_a_re, op_a_im, op_b_re, op_b_im,
    output op_ready,
    output res_val, res_re, res_im,
    input  res_ready,
    input  out_val, out_re, out_im,
    output out_ready
  );

endinterface

// File: rtl/cplx_mult_driver_op_fifo.sv
// cplx_op_fifo: synchronous operand FIFO, registered count, head visible without a pop.
module cplx_op_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     sw_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cplx_mult_driver.sv
// Initiator front end for the complex multiplier: buffer, issue one op, collect, hold result.
// Optional watchdog on the in-flight operation is compiled in with CMD_WATCHDOG_EN.
//
// state    | meaning
// IDLE     | waiting for a buffered operand set; loads op_* from the FIFO head
// ISSUE    | op_val high until the multiplier takes the operands
// WAIT_RES | waiting for the product; accepts it only when the output register is free
module cplx_mult_driver
  import cplx_mult_pkg::*;
#(
  parameter int DATA_W     = OP_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 sw_rst,
  cplx_mult_driver_if.master   bus,
  output logic                 mult_sw_rst,
  output logic [15:0]          done_cnt,
  output logic                 timeout_err
);

  localparam int RW = res_w(DATA_W);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  op_set_t     fifo_wdata;
  op_set_t     fifo_head;
  op_set_t     op_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic              out_val_q;
  logic signed [RW-1:0] out_re_q;
  logic signed [RW-1:0] out_im_q;

  logic op_fire;
  logic res_fire;
  logic wd_fire;

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.a_re = bus.in_a_re;
    fifo_wdata.a_im = bus.in_a_im;
    fifo_wdata.b_re = bus.in_b_re;
    fifo_wdata.b_im = bus.in_b_im;
  end

  assign bus.in_ready  = !fifo_full && !sw_rst;
  assign fifo_push     = bus.in_val && bus.in_ready;
  assign bus.op_val    = (state == ST_ISSUE);
  assign bus.res_ready = (state == ST_WAIT_RES) && !out_val_q;
  assign op_fire       = bus.op_val && bus.op_ready;
  assign res_fire      = bus.res_val && bus.res_ready;
  // a watchdog expiry in ISSUE drops the head entry along with the operation
  assign fifo_pop      = (state == ST_ISSUE) && (op_fire || wd_fire);

  assign bus.op_a_re = op_q.a_re;
  assign bus.op_a_im = op_q.a_im;
  assign bus.op_b_re = op_q.b_re;
  assign bus.op_b_im = op_q.b_im;
  assign bus.out_val = out_val_q;
  assign bus.out_re  = out_re_q;
  assign bus.out_im  = out_im_q;

  cplx_op_fifo #(
    .W     ($bits(op_set_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .sw_rst (sw_rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (fifo_wdata),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE:    if (wd_fire) state_nxt = ST_IDLE;
                   else if (op_fire) state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: if (wd_fire || res_fire) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      out_val_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      done_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && !fifo_empty) op_q <= fifo_head;
      if (out_val_q && bus.out_ready) out_val_q <= 1'b0;
      // capture overrides the clear so a same-cycle hand-off keeps out_val high
      if (res_fire && !wd_fire) begin
        out_val_q <= 1'b1;
        out_re_q  <= bus.res_re;
        out_im_q  <= bus.res_im;
        done_cnt  <= done_cnt + 16'd1;
      end
    end
  end

`ifdef CMD_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_pulse_q;

  assign wd_fire     = (state != ST_IDLE) && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign mult_sw_rst = sw_rst || wd_pulse_q;

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      wd_cnt      <= '0;
      wd_pulse_q  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wd_pulse_q <= wd_fire;
      if (wd_fire) timeout_err <= 1'b1;
      if (state == ST_IDLE || state_nxt != state) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
  assign mult_sw_rst = sw_rst;
`endif

endmodule

// File: tb/tb_cplx_mult_driver.sv
// Scoreboard bench for cplx_mult_driver with a latency-4 multiplier model and directed vectors.
module tb_cplx_mult_driver;

  typedef struct packed {
    logic signed [16:0] re;
    logic signed [16:0] im;
  } res_t;

  typedef struct {
    int ar; int ai; int br; int bi; int er; int ei;
  } vec_t;

  // hand-computed: re = ar*br - ai*bi, im = ar*bi + ai*br
  vec_t vecs [7] = '{
    '{   3,    4,    1,   -2,    11,     -2},
    '{-128, -128, -128, -128,     0,  32768},
    '{ 127, -128,  127,  127, 32385,   -127},
    '{   2,    5,   -3,    7,   -41,     -1},
    '{  10,    0,    0,   10,     0,    100},
    '{  -1,    1,    1,    1,    -2,      0},
    '{-128,  127, -128, -128, 32640,    128}
  };

  logic        clk = 1'b0;
  logic        sw_rst;
  logic        mult_sw_rst;
  logic [15:0] done_cnt;
  logic        timeout_err;

  cplx_mult_driver_if #(.DATA_W(8)) bus ();

  cplx_mult_driver #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .sw_rst      (sw_rst),
    .bus         (bus),
    .mult_sw_rst (mult_sw_rst),
    .done_cnt    (done_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q [$];

  bit   stall  = 1'b0;
  bit   no_res = 1'b0;
  int   op_cnt = 0;
  int   m_state = 0;
  int   m_lat = 0;
  logic signed [16:0] m_re = '0;
  logic signed [16:0] m_im = '0;

  function automatic logic signed [16:0] prod_re(input int ar, ai, br, bi);
    return 17'(ar * br - ai * bi);
  endfunction

  function automatic logic signed [16:0] prod_im(input int ar, ai, br, bi);
    return 17'(ar * bi + ai * br);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // multiplier model
  assign bus.op_ready = (m_state == 0) && !stall;
  assign bus.res_re   = m_re;
  assign bus.res_im   = m_im;
  initial bus.res_val = 1'b0;

  always @(posedge clk) begin
    if (mult_sw_rst) begin
      m_state     <= 0;
      bus.res_val <= 1'b0;
    end else begin
      case (m_state)
        0: if (bus.op_val && bus.op_ready) begin
             m_re    <= prod_re(bus.op_a_re, bus.op_a_im, bus.op_b_re, bus.op_b_im);
             m_im    <= prod_im(bus.op_a_re, bus.op_a_im, bus.op_b_re, bus.op_b_im);
             m_lat   <= 3;
             m_state <= 1;
             op_cnt  <= op_cnt + 1;
           end
        1: if (!no_res) begin
             if (m_lat == 0) begin
               bus.res_val <= 1'b1;
               m_state     <= 2;
             end else m_lat <= m_lat - 1;
           end
        default: if (bus.res_ready) begin
             bus.res_val <= 1'b0;
             m_state     <= 0;
           end
      endcase
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!sw_rst && bus.out_val && bus.out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got re=%0d im=%0d expected no result", bus.out_re, bus.out_im);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if (bus.out_re !== e.re || bus.out_im !== e.im) begin
          n_fail++;
          $display("FAIL out_data: got re=%0d im=%0d expected re=%0d im=%0d",
                   bus.out_re, bus.out_im, e.re, e.im);
        end
      end
    end
  end

  task automatic push_vec(input int idx, input bit expect_out);
    int n;
    @(posedge clk); #1;
    bus.in_a_re = 8'(vecs[idx].ar);
    bus.in_a_im = 8'(vecs[idx].ai);
    bus.in_b_re = 8'(vecs[idx].br);
    bus.in_b_im = 8'(vecs[idx].bi);
    bus.in_val  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("push_accept_timeout", 0, 1);
    @(posedge clk);
    if (expect_out) exp_q.push_back('{re: 17'(vecs[idx].er), im: 17'(vecs[idx].ei)});
    #1;
    bus.in_val = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_op_cnt(input int target, input string name);
    int n = 0;
    while (op_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, op_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    sw_rst        = 1'b1;
    bus.in_val    = 1'b0;
    bus.in_a_re   = '0;
    bus.in_a_im   = '0;
    bus.in_b_re   = '0;
    bus.in_b_im   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mult_sw_rst", mult_sw_rst, 1);
    check("rst_op_val", bus.op_val, 0);
    check("rst_res_ready", bus.res_ready, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_re", int'(bus.out_re), 0);
    check("rst_op_a_re", int'(bus.op_a_re), 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    sw_rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_mult_sw_rst", mult_sw_rst, 0);

    // single operation and issue latency
    base = op_cnt;
    push_vec(0, 1'b1);
    check("lat_e0_op_val", bus.op_val, 0);
    @(posedge clk); #1;
    check("lat_e1_op_val", bus.op_val, 1);
    check("lat_e1_op_a_re", int'(bus.op_a_re), 3);
    check("lat_e1_op_b_im", int'(bus.op_b_im), -2);
    wait_drain("single_drain");
    check("single_done_cnt", done_cnt, 1);
    check("single_op_pulses", op_cnt - base, 1);

    // back-pressure: fill the buffer, then hold the first result
    bus.out_ready = 1'b0;
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_vec(i, 1'b1);
    check("bp_full_in_ready", bus.in_ready, 0);
    stall = 1'b0;
    push_vec(5, 1'b1);
    n = 0;
    while (!bus.out_val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("bp_out_val_held", bus.out_val, 1);
    check("bp_res_ready_low", bus.res_ready, 0);
    check("bp_held_re", int'(bus.out_re), 0);
    check("bp_held_im", int'(bus.out_im), 32768);
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_done_cnt", done_cnt, 6);

    // operand stability under op_ready low
    stall = 1'b1;
    base = op_cnt;
    push_vec(6, 1'b1);
    push_vec(0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stab_op_val", bus.op_val, 1);
      check("stab_op_a_re", int'(bus.op_a_re), -128);
      check("stab_op_b_im", int'(bus.op_b_im), -128);
    end
    check("stab_no_pop", op_cnt - base, 0);
    stall = 1'b0;
    @(posedge clk); #1;
    check("stab_one_pop", op_cnt - base, 1);
    wait_drain("stab_drain");
    check("stab_total_pops", op_cnt - base, 2);
    check("stab_done_cnt", done_cnt, 8);

    // reset while an operation waits for its result with two sets buffered
    no_res = 1'b1;
    base = op_cnt;
    push_vec(0, 1'b0);
    push_vec(1, 1'b0);
    push_vec(2, 1'b0);
    wait_op_cnt(base + 1, "mid_issue");
    sw_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mid_rst_mult_sw_rst", mult_sw_rst, 1);
      check("mid_rst_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      check("mid_rst_out_val", bus.out_val, 0);
      check("mid_rst_done_cnt", done_cnt, 0);
    end
    sw_rst = 1'b0;
    no_res = 1'b0;
    base = op_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("mid_post_op_val", bus.op_val, 0);
    check("mid_post_no_issue", op_cnt - base, 0);
    check("mid_post_in_ready", bus.in_ready, 1);

    // done_cnt wrap
    force dut.done_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.done_cnt;
    push_vec(3, 1'b1);
    wait_drain("wrap_drain");
    check("wrap_done_cnt", done_cnt, 0);

`ifdef CMD_WATCHDOG_EN
    no_res = 1'b1;
    base = op_cnt;
    push_vec(2, 1'b0);
    wait_op_cnt(base + 1, "wd_issue");
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (mult_sw_rst) break;
    end
    check("wd_pulse_delay", n, 16);
    check("wd_timeout_err", timeout_err, 1);
    @(posedge clk); #1;
    check("wd_pulse_width", mult_sw_rst, 0);
    no_res = 1'b0;
    push_vec(4, 1'b1);
    wait_drain("wd_next_drain");
    check("wd_done_cnt", done_cnt, 1);
    check("wd_err_sticky", timeout_err, 1);
`else
    check("no_wd_timeout_err", timeout_err, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cplx_mult_driver.md
# cplx_mult_driver

Initiator-side front end for the complex-number multiplier. Buffers operand sets from an upstream source and issues them one at a time over the multiplier's op_val/op_ready handshake. Collects each product over the res_val/res_ready handshake and presents it downstream through a registered valid/ready output. Sits between the system operand source and the multiplier core; it is the producer and consumer on the other end of the multiplier's control interface.

## Interface
- DATA_W, 8: width of each operand component (signed)
- FIFO_DEPTH, 4: operand buffer depth, power of two, ≥2
- TIMEOUT, 64: watchdog limit in cycles (used only with the watchdog macro)
- clk  in  1  clock, all logic on the rising edge
- sw_rst  in  1  reset, synchronous, active-high
- in_val  in  1  upstream operand set valid
- in_ready  out  1  buffer can accept; = !full
- in_a_re, in_a_im, in_b_re, in_b_im  in  DATA_W each  operands A and B
- op_val  out  1  operand set valid toward the multiplier
- op_ready  in  1  multiplier accepts operands
- op_a_re, op_a_im, op_b_re, op_b_im  out  DATA_W each  registered operands to the multiplier
- res_val  in  1  multiplier result valid
- res_ready  out  1  driver accepts the result
- res_re, res_im  in  2*DATA_W+1 each  multiplier product
- out_val  out  1  result held for downstream
- out_ready  in  1  downstream accepts
- out_re, out_im  out  2*DATA_W+1 each  registered result
- mult_sw_rst  out  1  reset request to the multiplier
- done_cnt  out  16  completed-operation counter, wraps 0xFFFF→0
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, WAIT_RES.
- IDLE: if the FIFO is non-empty, load the op_* registers from the FIFO head and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: op_val = 1. On op_val&&op_ready, pop the FIFO and go to WAIT_RES.
- WAIT_RES: res_ready = !out_val. On res_val&&res_ready, capture res_re/res_im into out_*, set out_val, increment done_cnt, and go to IDLE.
- op_* hold stable from entry to ISSUE until WAIT_RES exits. Only one operation is in flight.
- Output register: out_val clears on out_val&&out_ready. If a new capture happens in the same cycle, out_val stays 1 and the new data is loaded.
- FIFO push on in_val&&in_ready. Push and pop in the same cycle leave count unchanged. A push while full cannot occur because in_ready=0.
- mult_sw_rst = sw_rst (combinational), OR'd with the watchdog pulse when the watchdog is compiled in.
- Widths: results pass through unmodified at 2*DATA_W+1 bits, with no truncation or sign extension.

## Timing
- Reset values: FSM state IDLE, FIFO empty, op_val 0, op_* 0, res_ready 0, out_val 0, out_* 0, done_cnt 0, timeout_err 0.
- While sw_rst=1, in_ready=0 and mult_sw_rst=1.
- sw_rst mid-operation discards all buffered operations, the in-flight operation and any held result. There is no partial output.
- Push accepted at edge E0 → FSM leaves IDLE at E1 → op_val high in the cycle after E1.
- After a result capture at edge Ec, the next issue can begin at Ec+1 (IDLE transition) if the FIFO is non-empty.
- out_val and done_cnt update at the same edge as the capture.

## Configuration
- Macro CMD_WATCHDOG_EN.
- Defined:
  - A counter runs while the FSM is in ISSUE or WAIT_RES and clears on every state change.
  - When the counter reaches TIMEOUT-1: mult_sw_rst pulses for one cycle, timeout_err is set (sticky until sw_rst), and the FSM returns to IDLE.
  - If the timeout occurs in ISSUE, the head entry is popped and dropped. done_cnt is not incremented.
- Undefined: no counter; timeout_err is tied 0; mult_sw_rst = sw_rst.

## Structure
- Package cplx_mult_pkg holds:
  - the FSM state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT_RES=2'b10);
  - the RES_W = 2*DATA_W+1 derivation;
  - the operand-set packed struct {a_re, a_im, b_re, b_im}.
- Sub-module cplx_op_fifo: synchronous FIFO with registered count, full/empty flags and a head read that needs no pop to observe.

## Test plan
- Single operation: A=(3,4), B=(1,-2), multiplier model with 4-cycle latency → out_re=11, out_im=-2, done_cnt=1, one op_val pulse.
- Back-pressure: push 5 sets with out_ready=0 → in_ready drops after 4 buffered. First result held; res_ready=0 until out_ready=1, then all 5 results arrive in order.
- Operand stability: model holds op_ready=0 for 10 cycles → op_val and op_* stay constant; exactly one pop when op_ready rises.
- Reset mid-flight: assert sw_rst during WAIT_RES with 2 sets buffered → next cycle FIFO empty, out_val=0, done_cnt=0, mult_sw_rst=1 for the reset duration.
- Watchdog (CMD_WATCHDOG_EN, TIMEOUT=16): model never asserts res_val → mult_sw_rst pulses once, 16 cycles after entering WAIT_RES, and timeout_err=1. The following set completes normally.
- Wrap: force done_cnt=0xFFFF and complete one operation → done_cnt=0x0000.
